// File: rtl/seq_detector_gen_pkg.sv
// Shared types and default sizes for the serial pattern detector.
package seq_det_pkg;
  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/seq_detector_gen_if.sv
// Configuration, bit-stream and result signals of the pattern detector.
interface seq_detector_gen_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  // in_valid qualifies in_bit with no back-pressure: a bit presented with
  // in_valid=1 is consumed in that cycle (unless cfg_load is also high).
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic             overlap_en;
  logic             in_valid;
  logic             in_bit;
  logic             clear_cnt;
  logic             mealy_y;
  logic             moore_y;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;
  state_t           dbg_state;

  modport master (
    output cfg_load, pattern, overlap_en, in_valid, in_bit, clear_cnt,
    input  mealy_y, moore_y, match_cnt, armed, dbg_state
  );

  modport slave (
    input  cfg_load, pattern, overlap_en, in_valid, in_bit, clear_cnt,
    output mealy_y, moore_y, match_cnt, armed, dbg_state
  );
endinterface

// File: rtl/seq_detector_gen_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_detector_gen.sv
// Run-time configurable serial pattern detector with Mealy/Moore flags and a
// saturating match counter.
module seq_detector_gen
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         reset,
  seq_detector_gen_if.slave bus
);
  localparam int                FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]     FILL_MAX = FW'(PAT_W - 1);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic             moore_q;
  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] window;

  assign window = {hist, bus.in_bit};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    hit       = 1'b0;
    if (bus.cfg_load) begin
      state_nxt = S_RUN;
    end else if (state == S_RUN) begin
      accept = bus.in_valid;
      hit    = bus.in_valid && (fill == FILL_MAX) && (window == pat_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: a non-overlapping hit restarts the window from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      moore_q <= 1'b0;
    end else if (bus.cfg_load) begin
      pat_q   <= bus.pattern;
      ovl_q   <= bus.overlap_en;
      hist    <= '0;
      fill    <= '0;
      moore_q <= 1'b0;
    end else if (accept) begin
      moore_q <= hit;
      if (hit && !ovl_q) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[PAT_W-2:0];
        if (fill != FILL_MAX) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (bus.clear_cnt),
    .inc   (hit),
    .cnt   (bus.match_cnt)
  );

  assign bus.mealy_y   = hit;
  assign bus.moore_y   = moore_q;
  assign bus.armed     = (state == S_RUN);
  assign bus.dbg_state = state;
endmodule

// File: doc/seq_detector_gen.md
Name: seq_detector_gen

Overview:
Parametrised serial pattern detector. It is the successor to the fixed-pattern Moore/Mealy sequence FSM. Pattern width is a parameter. The pattern and overlap mode are loaded at run time. Input bits are qualified by a valid strobe, and a saturating match counter is added. It sits on a serial bit stream and flags pattern occurrences to downstream control logic.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the saturating match counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
cfg_load  input  1  one-cycle strobe: latch pattern/overlap_en, restart detection
pattern  input  PAT_W  target pattern; MSB is the first bit received
overlap_en  input  1  1 = overlapping matches allowed; 0 = non-overlapping
in_valid  input  1  in_bit is accepted this cycle when 1
in_bit  input  1  serial data bit
clear_cnt  input  1  synchronous clear of match_cnt
mealy_y  output  1  combinational match flag, same cycle as the completing bit
moore_y  output  1  registered match flag, one cycle after the completing bit
match_cnt  output  CNT_W  number of matches, saturating
armed  output  1  high in S_RUN

Behaviour:
- Reset (reset=0, async): state=S_IDLE; pat_q=0, ovl_q=0, hist=0, fill=0, moore_y=0, match_cnt=0. Consequently mealy_y=0 and armed=0.
- FSM has two states, S_IDLE and S_RUN.
  - S_IDLE: in_bit is ignored and all flags are 0.
  - cfg_load=1 in any state: pat_q<=pattern, ovl_q<=overlap_en, hist<=0, fill<=0, moore_y<=0, state<=S_RUN. In that cycle in_bit is ignored and mealy_y=0. match_cnt is not affected.
- hist is a PAT_W-1 bit shift register holding previously accepted bits, newest in the LSB.
- fill is a counter of accepted bits since the last restart, saturating at PAT_W-1.
- hit = (state==S_RUN) & in_valid & ~cfg_load & (fill==PAT_W-1) & ({hist,in_bit}==pat_q).
- mealy_y = hit, purely combinational. It is high only while the completing bit is present.
- On each accepted bit (S_RUN, in_valid=1, cfg_load=0):
  - hist<={hist[PAT_W-3:0],in_bit}.
  - moore_y<=hit.
  - fill: if hit and ovl_q=0, fill<=0 and hist is cleared. Otherwise fill<=min(fill+1, PAT_W-1).
- in_valid=0: hist, fill and moore_y hold. moore_y therefore stays high until the next accepted bit.
- match_cnt:
  - clear_cnt=1 -> 0. Clear has priority over a simultaneous hit.
  - Otherwise, on hit, increments by 1, saturating at 2^CNT_W-1.
- A reset asserted mid-stream aborts immediately. The block returns to S_IDLE and needs cfg_load before it detects again.
- Changing pattern or overlap_en without cfg_load has no effect.

Decomposition:
- Package seq_det_pkg holds:
  - state typedef enum logic {S_IDLE, S_RUN}.
  - Default constants PAT_W_DEF=4 and CNT_W_DEF=8.
- One sub-module, sat_counter (CNT_W, async active-low reset, clr, inc, saturating), used for match_cnt.
- The FSM, shift register and fill counter stay in the top.

Test Plan:
1. Reset then idle: reset=0 for 5 ns, then in_valid=1 streaming bits with no cfg_load -> mealy_y=moore_y=0, armed=0, match_cnt=0 throughout.
2. Basic detect: PAT_W=4, cfg_load with pattern=4'b1011, overlap_en=0, then bits 0,1,0,0,1,1,0,1,1,1 one per cycle -> single hit. mealy_y=1 in the cycle of bit index 8 only; moore_y=1 for the following cycle; match_cnt=1.
3. Overlap mode:
   - pattern=4'b1101, overlap_en=1, stream 1,1,0,1,1,0,1 -> hits on bits 3 and 6; match_cnt=2.
   - Same stream with overlap_en=0 -> hit on bit 3 only; match_cnt=1.
4. Valid gating: pattern 1101, with in_valid=0 bubbles of 3 cycles inserted between each bit -> same hits as the gapless run. moore_y holds 1 across the bubbles after the match until the next accepted bit.
5. Counter edges:
   - CNT_W=2, pattern 4'b1111, overlap_en=1, ten consecutive 1s -> match_cnt saturates at 3.
   - clear_cnt asserted in the same cycle as a hit -> match_cnt=0.
6. Reconfig and reset mid-stream:
   - cfg_load with 1101 after bits 1,1,0 -> the next bit 1 does not hit (fill restarted).
   - reset pulsed low mid-stream -> outputs go to 0 asynchronously before the next clk edge, and armed=0.
